// File: rtl/prim_onehot_stream_mux.sv
// One-hot selected valid/ready stream mux with an AND/OR datapath and an optional
// full-throughput 2-entry skid buffer on the output.
module prim_onehot_stream_mux #(
    parameter int Width  = 32,
    parameter int Inputs = 8,
    parameter bit OutReg = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [Inputs-1:0] in_valid_i,
    output logic [Inputs-1:0] in_ready_o,
    input  logic [Width-1:0]  in_data_i [Inputs],
    input  logic [Inputs-1:0] sel_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [Width-1:0]  out_data_o,
    output logic              sel_err_o,
    input  logic              sel_err_clr_i,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a beat moves on a channel in any cycle where that channel's valid
    // and ready are both high; the producer holds valid and data stable until then,
    // and out_valid_o/out_data_o likewise hold until out_ready_i.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FULL  = 2'd2
    } state_e;

    logic              sel_ok;
    logic [Inputs-1:0] eff_sel;
    logic              mux_valid;
    logic [Width-1:0]  mux_data;

    assign sel_ok    = $onehot0(sel_i);
    assign eff_sel   = sel_ok ? sel_i : '0;
    assign mux_valid = |(in_valid_i & eff_sel);

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < Inputs; i++) begin
            mux_data = mux_data | (in_data_i[i] & {Width{eff_sel[i]}});
        end
    end

    // Set has priority over clear so an illegal select is never lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sel_err_o <= 1'b0;
        end else if (!sel_ok) begin
            sel_err_o <= 1'b1;
        end else if (sel_err_clr_i) begin
            sel_err_o <= 1'b0;
        end
    end

    if (OutReg) begin : g_skid
        state_e           state_q;
        logic             can_accept_q;
        logic             accept;
        logic [Width-1:0] m_q;
        logic [Width-1:0] s_q;

        assign accept      = mux_valid & can_accept_q;
        assign in_ready_o  = eff_sel & {Inputs{can_accept_q}};
        assign out_valid_o = (state_q != EMPTY);
        assign out_data_o  = m_q;
        assign dbg_state_o = state_q;

        // can_accept_q tracks "next state is not FULL" so in_ready_o never
        // depends combinationally on out_ready_i.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q      <= EMPTY;
                can_accept_q <= 1'b0;
                m_q          <= '0;
                s_q          <= '0;
            end else begin
                case (state_q)
                    EMPTY: begin
                        can_accept_q <= 1'b1;
                        if (accept) begin
                            m_q     <= mux_data;
                            state_q <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (accept && out_ready_i) begin
                            m_q          <= mux_data;
                            can_accept_q <= 1'b1;
                        end else if (accept) begin
                            s_q          <= mux_data;
                            state_q      <= FULL;
                            can_accept_q <= 1'b0;
                        end else if (out_ready_i) begin
                            state_q      <= EMPTY;
                            can_accept_q <= 1'b1;
                        end else begin
                            can_accept_q <= 1'b1;
                        end
                    end
                    FULL: begin
                        if (out_ready_i) begin
                            m_q          <= s_q;
                            state_q      <= HOLD;
                            can_accept_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q      <= EMPTY;
                        can_accept_q <= 1'b0;
                    end
                endcase
            end
        end
    end else begin : g_pass
        assign in_ready_o  = eff_sel & {Inputs{out_ready_i}};
        assign out_valid_o = mux_valid;
        assign out_data_o  = mux_data;
        assign dbg_state_o = 2'd0;
    end

endmodule

// File: tb/tb_prim_onehot_stream_mux.sv
// Directed bench for prim_onehot_stream_mux: skid-buffered instance plus a
// combinational pass-through instance, all checks against hand-computed values.
module tb_prim_onehot_stream_mux;

    localparam int W = 32;
    localparam int N = 4;

    logic          clk;
    logic          rst_n;

    // registered instance
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  in_data [N];
    logic [N-1:0]  sel;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          sel_err;
    logic          sel_err_clr;
    logic [1:0]    dbg_state;

    // pass-through instance
    logic [N-1:0]  in_valid0;
    logic [N-1:0]  in_ready0;
    logic [W-1:0]  in_data0 [N];
    logic [N-1:0]  sel0;
    logic          out_valid0;
    logic          out_ready0;
    logic [W-1:0]  out_data0;
    logic          sel_err0;
    logic          sel_err_clr0;
    logic [1:0]    dbg_state0;

    int total = 0;
    int bad   = 0;

    prim_onehot_stream_mux #(.Width(W), .Inputs(N), .OutReg(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .sel_i(sel), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .sel_err_o(sel_err), .sel_err_clr_i(sel_err_clr),
        .dbg_state_o(dbg_state)
    );

    prim_onehot_stream_mux #(.Width(W), .Inputs(N), .OutReg(1'b0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid0), .in_ready_o(in_ready0), .in_data_i(in_data0),
        .sel_i(sel0), .out_valid_o(out_valid0), .out_ready_i(out_ready0),
        .out_data_o(out_data0), .sel_err_o(sel_err0), .sel_err_clr_i(sel_err_clr0),
        .dbg_state_o(dbg_state0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid    = '0;
        sel         = '0;
        out_ready   = 1'b0;
        sel_err_clr = 1'b0;
        for (int i = 0; i < N; i++) in_data[i] = '0;
    endtask

    initial begin
        idle_inputs();
        in_valid0    = '0;
        sel0         = '0;
        out_ready0   = 1'b0;
        sel_err_clr0 = 1'b0;
        for (int i = 0; i < N; i++) in_data0[i] = '0;
        rst_n = 1'b0;
        sel   = 4'b0010;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sel_err", sel_err, 0);
        check("rst_state", dbg_state, 0);

        // release between edges; ready only rises after the next edge
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", in_ready, 0);
        cyc();
        check("rel_in_ready_high", in_ready, 4'b0010);

        // 1: ch1 streams 0x11,0x22,0x33 with out_ready=1
        in_valid   = 4'b0010;
        in_data[1] = 32'h11;
        out_ready  = 1'b1;
        #1;
        check("t1_in_ready", in_ready, 4'b0010);
        check("t1_pre_valid", out_valid, 0);
        cyc();
        check("t1_b0_valid", out_valid, 1);
        check("t1_b0_data", out_data, 32'h11);
        in_data[1] = 32'h22;
        cyc();
        check("t1_b1_data", out_data, 32'h22);
        check("t1_b1_ready", in_ready, 4'b0010);
        in_data[1] = 32'h33;
        cyc();
        check("t1_b2_data", out_data, 32'h33);
        check("t1_b2_valid", out_valid, 1);
        in_valid = '0;
        cyc();
        check("t1_drain_valid", out_valid, 0);

        // 2: backpressure fills M and S, then drains in order
        sel        = 4'b0001;
        out_ready  = 1'b0;
        in_valid   = 4'b0001;
        in_data[0] = 32'hA;
        cyc();
        check("t2_a_data", out_data, 32'hA);
        check("t2_a_ready", in_ready, 4'b0001);
        in_data[0] = 32'hB;
        cyc();
        check("t2_full_state", dbg_state, 2);
        check("t2_full_ready", in_ready, 0);
        check("t2_full_data", out_data, 32'hA);
        in_data[0] = 32'hC;
        cyc();
        check("t2_hold_data", out_data, 32'hA);
        check("t2_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        cyc();
        check("t2_b_data", out_data, 32'hB);
        check("t2_b_ready", in_ready, 4'b0001);
        cyc();
        check("t2_c_data", out_data, 32'hC);
        in_valid = '0;
        cyc();
        check("t2_empty_valid", out_valid, 0);

        // 3: illegal select blocks handshakes and sets the sticky error
        sel         = 4'b0110;
        in_valid    = 4'b0110;
        in_data[1]  = 32'h1111;
        in_data[2]  = 32'h2222;
        #1;
        check("t3_in_ready", in_ready, 0);
        cyc();
        check("t3_valid", out_valid, 0);
        check("t3_err", sel_err, 1);
        sel      = 4'b0000;
        in_valid = '0;
        cyc();
        check("t3_err_sticky", sel_err, 1);
        check("t3_valid_still", out_valid, 0);
        sel_err_clr = 1'b1;
        cyc();
        check("t3_err_clr", sel_err, 0);
        sel = 4'b1001;
        cyc();
        check("t3_set_wins", sel_err, 1);
        sel = 4'b0000;
        cyc();
        check("t3_err_clr2", sel_err, 0);
        sel_err_clr = 1'b0;

        // 4: select moves to ch3 while 0x5 sits in M
        sel        = 4'b0001;
        out_ready  = 1'b0;
        in_valid   = 4'b0001;
        in_data[0] = 32'h5;
        cyc();
        check("t4_m_data", out_data, 32'h5);
        sel        = 4'b1000;
        in_valid   = 4'b1000;
        in_data[0] = 32'h0;
        in_data[3] = 32'h77;
        #1;
        check("t4_ch3_ready", in_ready, 4'b1000);
        cyc();
        check("t4_first_data", out_data, 32'h5);
        check("t4_full_state", dbg_state, 2);
        in_valid  = '0;
        out_ready = 1'b1;
        cyc();
        check("t4_second_data", out_data, 32'h77);
        check("t4_second_valid", out_valid, 1);
        cyc();
        check("t4_empty_valid", out_valid, 0);

        // 5: asynchronous reset while FULL
        sel        = 4'b0001;
        out_ready  = 1'b0;
        in_valid   = 4'b0001;
        in_data[0] = 32'h1;
        cyc();
        in_data[0] = 32'h2;
        cyc();
        check("t5_full_ready", in_ready, 0);
        check("t5_full_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_ready", in_ready, 0);
        check("t5_rst_data", out_data, 0);
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t5_rel_ready_low", in_ready, 0);
        cyc();
        check("t5_rel_ready_high", in_ready, 4'b0001);
        in_valid   = 4'b0001;
        in_data[0] = 32'h3;
        out_ready  = 1'b1;
        cyc();
        check("t5_first_valid", out_valid, 1);
        check("t5_first_data", out_data, 32'h3);
        in_valid = '0;
        cyc();
        check("t5_drain_valid", out_valid, 0);

        // 6: pass-through instance
        in_valid0   = 4'b1000;
        in_data0[3] = 32'hDEAD_BEEF;
        sel0        = 4'b0000;
        out_ready0  = 1'b1;
        #1;
        check("t6_sel0_valid", out_valid0, 0);
        check("t6_sel0_ready", in_ready0, 0);
        sel0 = 4'b1000;
        #1;
        check("t6_valid", out_valid0, 1);
        check("t6_data", out_data0, 32'hDEAD_BEEF);
        check("t6_ready_hi", in_ready0, 4'b1000);
        out_ready0 = 1'b0;
        #1;
        check("t6_ready_lo", in_ready0, 0);
        check("t6_valid_lo_ready", out_valid0, 1);
        in_data0[3] = 32'h0BAD_F00D;
        out_ready0  = 1'b1;
        #1;
        check("t6_data2", out_data0, 32'h0BAD_F00D);
        check("t6_ready_hi2", in_ready0, 4'b1000);
        in_valid0 = '0;
        #1;
        check("t6_valid_drop", out_valid0, 0);
        sel0 = 4'b0011;
        #1;
        check("t6_illegal_ready", in_ready0, 0);
        cyc();
        check("t6_err", sel_err0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
